// File: rtl/regfile_port_seq.sv
// regfile_port_seq: serializes one write-back or one two-operand read onto the
// single addr/d_in/we_ port of a register file. Write-back has priority.
// Optional build macro REGSEQ_R0_ZERO_EN: register 0 reads as zero and is never written.
module regfile_port_seq #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              i_wb_valid,
    output logic              o_wb_ready,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_rd_valid,
    output logic              o_rd_ready,
    input  logic [ADDR_W-1:0] i_rs_a,
    input  logic [ADDR_W-1:0] i_rs_b,
    output logic              o_rd_done,
    output logic [DATA_W-1:0] o_op_a,
    output logic [DATA_W-1:0] o_op_b,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_rf_addr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_rf_we_,
    input  logic [DATA_W-1:0] i_rf_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RDA  = 3'd2,
        S_RDB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_wb_ready;
    logic                r_busy;
    logic                r_rd_done;
    logic                r_rf_we_;
    logic [ADDR_W-1:0]   r_rf_addr;
    logic [DATA_W-1:0]   r_rf_wdata;
    logic [ADDR_W-1:0]   r_rs_b;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_wr_en_;

    // Read data as captured into op_a/op_b, and the write strobe level for an accepted write.
`ifdef REGSEQ_R0_ZERO_EN
    assign w_rdata  = (r_rf_addr == '0) ? '0 : i_rf_rdata;
    assign w_wr_en_ = (i_wb_addr == '0);
`else
    assign w_rdata  = i_rf_rdata;
    assign w_wr_en_ = 1'b0;
`endif

    // A read is only offered when idle and no write-back is competing for the port.
    assign o_rd_ready = r_wb_ready & ~i_wb_valid;

    assign o_wb_ready = r_wb_ready;
    assign o_busy     = r_busy;
    assign o_rd_done  = r_rd_done;
    assign o_rf_we_   = r_rf_we_;
    assign o_rf_addr  = r_rf_addr;
    assign o_rf_wdata = r_rf_wdata;
    assign o_op_a     = r_op_a;
    assign o_op_b     = r_op_b;

    // Sequencer FSM; rf_addr/rf_wdata double as the latched write request and rs_a,
    // and every output is loaded one edge ahead so it is a pure function of state.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state    <= S_IDLE;
            r_wb_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_rd_done  <= 1'b0;
            r_rf_we_   <= 1'b1;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_rs_b     <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_wb_valid) begin
                        r_state    <= S_WR;
                        r_wb_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_rf_addr  <= i_wb_addr;
                        r_rf_wdata <= i_wb_data;
                        r_rf_we_   <= w_wr_en_;
                    end else if (i_rd_valid) begin
                        r_state    <= S_RDA;
                        r_wb_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_rf_addr  <= i_rs_a;
                        r_rs_b     <= i_rs_b;
                    end
                end
                S_WR: begin
                    r_state    <= S_IDLE;
                    r_wb_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_rf_we_   <= 1'b1;
                end
                S_RDA: begin
                    r_state   <= S_RDB;
                    r_op_a    <= w_rdata;
                    r_rf_addr <= r_rs_b;
                end
                S_RDB: begin
                    r_state   <= S_DONE;
                    r_op_b    <= w_rdata;
                    r_rd_done <= 1'b1;
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_rd_done  <= 1'b0;
                    r_wb_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wb_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_rd_done  <= 1'b0;
                    r_rf_we_   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_seq.sv
// Bench for regfile_port_seq with a behavioural register file and an operand scoreboard.
module tb_regfile_port_seq;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NREG = 32;

    logic          clk = 1'b0;
    logic          reset_;
    logic          i_wb_valid, i_rd_valid;
    logic [AW-1:0] i_wb_addr, i_rs_a, i_rs_b;
    logic [DW-1:0] i_wb_data;
    logic          o_wb_ready, o_rd_ready, o_rd_done, o_busy, o_rf_we_;
    logic [DW-1:0] o_op_a, o_op_b, o_rf_wdata;
    logic [AW-1:0] o_rf_addr;
    logic [DW-1:0] i_rf_rdata;

    logic [DW-1:0] mem [NREG];
    logic [DW-1:0] refm [NREG];
    logic          init_req;
    logic [2*DW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            we_low_cnt = 0;
    logic          prev_done = 1'b0;

    always #5 clk = ~clk;

    regfile_port_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_(reset_),
        .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
        .i_rs_a(i_rs_a), .i_rs_b(i_rs_b),
        .o_rd_done(o_rd_done), .o_op_a(o_op_a), .o_op_b(o_op_b),
        .o_busy(o_busy), .o_rf_addr(o_rf_addr), .o_rf_wdata(o_rf_wdata),
        .o_rf_we_(o_rf_we_), .i_rf_rdata(i_rf_rdata)
    );

    // Behavioural single-port register file: combinational read, write on edge when we_ low.
    assign i_rf_rdata = mem[o_rf_addr];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < NREG; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (!o_rf_we_) begin
            mem[o_rf_addr] <= o_rf_wdata;
        end
    end

    // Expected read value of one register according to the reference model.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef REGSEQ_R0_ZERO_EN
        if (a == '0) return '0;
`endif
        return refm[a];
    endfunction

    // Output monitor: scoreboard pop on rd_done, pulse-width check, write-strobe counter.
    always @(negedge clk) begin
        logic [2*DW-1:0] e;
        if (!o_rf_we_) we_low_cnt = we_low_cnt + 1;
        if (reset_ && o_rd_done) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL rd_done_pulse: rd_done high two cycles in a row, required one");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_done_unexpected: strobe with no read outstanding");
            end else begin
                e = exp_q.pop_front();
                if ({o_op_a, o_op_b} !== e) begin
                    errors++;
                    $display("FAIL operands: op_a=%h op_b=%h required op_a=%h op_b=%h",
                             o_op_a, o_op_b, e[2*DW-1:DW], e[DW-1:0]);
                end
            end
        end
        prev_done = o_rd_done;
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        @(negedge clk);
        i_wb_valid = 1'b1; i_wb_addr = a; i_wb_data = d;
        #1;
        n = 0;
        while (!o_wb_ready && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (!o_wb_ready) begin
            errors++;
            $display("FAIL wb_accept_timeout: wb_ready=%b required 1", o_wb_ready);
        end else begin
`ifdef REGSEQ_R0_ZERO_EN
            if (a != '0) refm[a] = d;
`else
            refm[a] = d;
`endif
        end
        @(negedge clk);
        i_wb_valid = 1'b0;
    endtask

    // Issue a read, wait for its strobe; lat counts negedges from acceptance to rd_done.
    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b, output int lat);
        int n;
        @(negedge clk);
        i_rd_valid = 1'b1; i_rs_a = a; i_rs_b = b;
        #1;
        n = 0;
        while (!o_rd_ready && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (!o_rd_ready) begin
            errors++;
            $display("FAIL rd_accept_timeout: rd_ready=%b required 1", o_rd_ready);
            i_rd_valid = 1'b0;
            lat = -1;
            return;
        end
        exp_q.push_back({exp_rd(a), exp_rd(b)});
        @(negedge clk);
        i_rd_valid = 1'b0;
        lat = 1;
        while (!o_rd_done && lat < 10) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        reset_ = 1'b0; init_req = 1'b1;
        i_wb_valid = 1'b0; i_rd_valid = 1'b0;
        i_wb_addr = '0; i_wb_data = '0; i_rs_a = '0; i_rs_b = '0;
        for (int i = 0; i < NREG; i++) refm[i] = 32'hC0DE_0000 + 32'(i);
        repeat (2) @(negedge clk);
        init_req = 1'b0;
        checks++;
        if ({o_rf_we_, o_busy, o_rd_done, o_wb_ready, o_rd_ready} !== 5'b10011) begin
            errors++;
            $display("FAIL reset_ctrl: we_,busy,done,wb_rdy,rd_rdy=%b required 10011",
                     {o_rf_we_, o_busy, o_rd_done, o_wb_ready, o_rd_ready});
        end
        checks++;
        if ({o_op_a, o_op_b, o_rf_wdata, o_rf_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: op_a=%h op_b=%h wdata=%h addr=%h required all 0",
                     o_op_a, o_op_b, o_rf_wdata, o_rf_addr);
        end
        reset_ = 1'b1;
    endtask

    // Reset asserted while WR drives the regfile: the write must be dropped.
    task automatic test_reset_mid_wr();
        @(negedge clk);
        i_wb_valid = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'h5555_AAAA;
        @(posedge clk); #1;
        checks++;
        if (o_rf_we_ !== 1'b0) begin
            errors++;
            $display("FAIL mid_wr_enter: rf_we_=%b required 0", o_rf_we_);
        end
        reset_ = 1'b0; i_wb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_rf_we_, o_busy, o_rd_done} !== 3'b100 || o_op_a !== '0 || o_op_b !== '0) begin
            errors++;
            $display("FAIL mid_wr_reset: we_,busy,done=%b op_a=%h op_b=%h required 100,0,0",
                     {o_rf_we_, o_busy, o_rd_done}, o_op_a, o_op_b);
        end
        @(negedge clk);
        checks++;
        if (mem[9] !== 32'hC0DE_0009) begin
            errors++;
            $display("FAIL mid_wr_mem: r9=%h required c0de0009", mem[9]);
        end
        reset_ = 1'b1;
    endtask

    task automatic test_write_read();
        int lat;
        we_low_cnt = 0;
        do_write(5'd3, 32'h0000_1234);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (we_low_cnt !== 1) begin
            errors++;
            $display("FAIL wr_strobe_len: rf_we_ low %0d cycles required 1", we_low_cnt);
        end
        do_read(5'd3, 5'd3, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL rd_latency: %0d cycles required 3", lat);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        @(negedge clk);
        i_wb_valid = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hA5A5_A5A5;
        i_rd_valid = 1'b1; i_rs_a = 5'd5; i_rs_b = 5'd1;
        #1;
        checks++;
        if ({o_wb_ready, o_rd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL sim_ready: wb_ready,rd_ready=%b required 10", {o_wb_ready, o_rd_ready});
        end
        refm[5] = 32'hA5A5_A5A5;
        @(negedge clk);
        i_wb_valid = 1'b0;
        #1;
        n = 0;
        while (!o_rd_ready && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (!o_rd_ready || mem[5] !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL sim_order: rd_ready=%b r5=%h required 1 a5a5a5a5", o_rd_ready, mem[5]);
        end
        exp_q.push_back({exp_rd(5'd5), exp_rd(5'd1)});
        @(negedge clk);
        i_rd_valid = 1'b0;
        n = 0;
        while (!o_rd_done && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (o_op_a !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL sim_op_a: op_a=%h required a5a5a5a5", o_op_a);
        end
    endtask

    task automatic test_two_writes();
        int lat;
        do_write(5'd7, 32'hDEAD_BEEF);
        do_write(5'd8, 32'h0BAD_F00D);
        do_read(5'd8, 5'd7, lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (o_op_a !== 32'h0BAD_F00D || o_op_b !== 32'hDEAD_BEEF || o_rd_done !== 1'b0) begin
                errors++;
                $display("FAIL hold_ops: op_a=%h op_b=%h done=%b required 0badf00d deadbeef 0",
                         o_op_a, o_op_b, o_rd_done);
            end
        end
    endtask

    task automatic test_r0();
        int lat;
        logic [DW-1:0] want;
        int want_we;
`ifdef REGSEQ_R0_ZERO_EN
        want = '0; want_we = 0;
`else
        want = 32'hFFFF_FFFF; want_we = 1;
`endif
        we_low_cnt = 0;
        do_write(5'd0, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (we_low_cnt !== want_we) begin
            errors++;
            $display("FAIL r0_we: rf_we_ low %0d cycles required %0d", we_low_cnt, want_we);
        end
        do_read(5'd0, 5'd4, lat);
        checks++;
        if (o_op_a !== want) begin
            errors++;
            $display("FAIL r0_read: op_a=%h required %h", o_op_a, want);
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int n;
        accepts = 0;
        @(negedge clk);
        i_rd_valid = 1'b1; i_rs_a = 5'd7; i_rs_b = 5'd8;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (o_busy !== logic'(i % 4 != 0)) begin
                errors++;
                $display("FAIL b2b_busy: cycle %0d busy=%b required %b", i, o_busy, (i % 4 != 0));
            end
            if (o_rd_ready) begin
                accepts++;
                exp_q.push_back({exp_rd(5'd7), exp_rd(5'd8)});
            end
            @(negedge clk);
        end
        i_rd_valid = 1'b0;
        checks++;
        if (accepts !== 3) begin
            errors++;
            $display("FAIL b2b_accepts: %0d accepts required 3", accepts);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d reads outstanding required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wr();
        test_write_read();
        test_simultaneous();
        test_two_writes();
        test_r0();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
